// File: rtl/finder_scan.sv
// Raster scan of the binarized frame for 1:1:3:1:1 finder runs; sets column/row bitmap bits.
// Latency: one address per cycle; patterns_valid pulses 2*(WIDTH*HEIGHT+READ_LATENCY)+1 cycles after start.
// No backpressure: the read port returns a pixel exactly READ_LATENCY cycles after each address.
module finder_scan #(
    parameter int HEIGHT       = 480,
    parameter int WIDTH        = 480,
    parameter int READ_LATENCY = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start_scan,
    input  logic         pixel_reading,
    output logic [19:0]  address_reading,
    output logic [479:0] horz_patterns,
    output logic [479:0] vert_patterns,
    output logic         patterns_valid,
    output logic         busy
);

    typedef struct packed {
        logic       vld;
        logic       vert;
        logic [8:0] fast;
        logic       eol;
    } rd_tag_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HSCAN  = 3'd1;
    localparam logic [2:0] S_HDRAIN = 3'd2;
    localparam logic [2:0] S_VSCAN  = 3'd3;
    localparam logic [2:0] S_VDRAIN = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [8:0]  X_LAST = 9'(WIDTH - 1);
    localparam logic [8:0]  Y_LAST = 9'(HEIGHT - 1);
    localparam logic [7:0]  D_LAST = 8'(READ_LATENCY - 1);
    localparam logic [19:0] W20    = 20'(WIDTH);

    logic [2:0] state, state_nxt;
    logic [8:0] x, y, x_nxt, y_nxt;
    logic [7:0] drain_cnt, drain_nxt;
    logic       scan_clr;
    rd_tag_t    iss;

    // ------------------------------------------------------------------
    // Scan sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        drain_nxt = drain_cnt;
        iss       = '0;
        scan_clr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_scan) begin
                    state_nxt = S_HSCAN;
                    x_nxt     = '0;
                    y_nxt     = '0;
                    scan_clr  = 1'b1;
                    iss.vld   = 1'b1;
                end
            end
            S_HSCAN: begin
                if (x == X_LAST && y == Y_LAST) begin
                    state_nxt = S_HDRAIN;
                    drain_nxt = '0;
                end else begin
                    if (x == X_LAST) begin
                        x_nxt = '0;
                        y_nxt = y + 9'd1;
                    end else begin
                        x_nxt = x + 9'd1;
                    end
                    iss.vld  = 1'b1;
                    iss.fast = x_nxt;
                    iss.eol  = (x_nxt == X_LAST);
                end
            end
            S_HDRAIN: begin
                if (drain_cnt == D_LAST) begin
                    state_nxt = S_VSCAN;
                    x_nxt     = '0;
                    y_nxt     = '0;
                    iss.vld   = 1'b1;
                    iss.vert  = 1'b1;
                end else begin
                    drain_nxt = drain_cnt + 8'd1;
                end
            end
            S_VSCAN: begin
                if (x == X_LAST && y == Y_LAST) begin
                    state_nxt = S_VDRAIN;
                    drain_nxt = '0;
                end else begin
                    if (y == Y_LAST) begin
                        y_nxt = '0;
                        x_nxt = x + 9'd1;
                    end else begin
                        y_nxt = y + 9'd1;
                    end
                    iss.vld  = 1'b1;
                    iss.vert = 1'b1;
                    iss.fast = y_nxt;
                    iss.eol  = (y_nxt == Y_LAST);
                end
            end
            S_VDRAIN: begin
                if (drain_cnt == D_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    drain_nxt = drain_cnt + 8'd1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= S_IDLE;
            x               <= '0;
            y               <= '0;
            drain_cnt       <= '0;
            address_reading <= '0;
        end else begin
            state     <= state_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            drain_cnt <= drain_nxt;
            if (iss.vld) begin
                address_reading <= 20'(x_nxt) + 20'(y_nxt) * W20;
            end
        end
    end

    // Slot 0 mirrors the address register; slots 1..READ_LATENCY are the
    // delay line, so the last slot lines up with the returning pixel.
    rd_tag_t tag_pipe [0:READ_LATENCY];
    rd_tag_t rt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i <= READ_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= iss;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign rt = tag_pipe[READ_LATENCY];

    // ------------------------------------------------------------------
    // Run tracking and 1:1:3:1:1 evaluation
    // ------------------------------------------------------------------
    logic       cur_col;
    logic [8:0] cur_len, r0, r1, r2, r3;
    logic [2:0] cnt;
    logic       ext;
    logic [8:0] len_inc;
    logic [2:0] cnt_inc;

    assign ext     = (pixel_reading == cur_col);
    assign len_inc = (cur_len == 9'h1FF) ? cur_len : cur_len + 9'd1;
    assign cnt_inc = (cnt == 3'd5) ? cnt : cnt + 3'd1;

    logic       ev_en;
    logic [8:0] e_r0, e_r1, e_r2, e_r3, e_r4, p_last;
    logic [2:0] e_cnt;

    // A line-end pixel that flips white->black must first push the white run
    // into history so the one-pixel black run sees a complete window.
    always_comb begin
        ev_en  = 1'b0;
        e_r0   = r0;
        e_r1   = r1;
        e_r2   = r2;
        e_r3   = r3;
        e_r4   = cur_len;
        e_cnt  = cnt;
        p_last = rt.fast - 9'd1;
        if (rt.vld) begin
            if (!cur_col && !ext) begin
                ev_en = 1'b1;
            end else if (!cur_col && rt.eol) begin
                ev_en  = 1'b1;
                e_r4   = len_inc;
                p_last = rt.fast;
            end else if (cur_col && !ext && rt.eol) begin
                ev_en  = 1'b1;
                e_r0   = r1;
                e_r1   = r2;
                e_r2   = r3;
                e_r3   = cur_len;
                e_cnt  = cnt_inc;
                e_r4   = 9'd1;
                p_last = rt.fast;
            end
        end
    end

    function automatic logic in_band(input logic [13:0] v,
                                     input logic [13:0] lo,
                                     input logic [13:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic [11:0] sum_t, center;
    logic [13:0] t14, m0, m1, m2, m3, m4;
    logic        ratio_ok, hit;

    assign sum_t = 12'(e_r0) + 12'(e_r1) + 12'(e_r2) + 12'(e_r3) + 12'(e_r4);
    assign t14   = 14'(sum_t);
    assign m0    = 14'(e_r0) * 14'd14;
    assign m1    = 14'(e_r1) * 14'd14;
    assign m2    = 14'(e_r2) * 14'd7;
    assign m3    = 14'(e_r3) * 14'd14;
    assign m4    = 14'(e_r4) * 14'd14;

    assign ratio_ok = (sum_t >= 12'd7)
                    && in_band(m0, t14, t14 * 14'd3)
                    && in_band(m1, t14, t14 * 14'd3)
                    && in_band(m3, t14, t14 * 14'd3)
                    && in_band(m4, t14, t14 * 14'd3)
                    && in_band(m2, t14 * 14'd2, t14 * 14'd4);

    assign center = 12'(p_last) - 12'(e_r4) - 12'(e_r3) - 12'(e_r2 >> 1);
    assign hit    = ev_en && (e_cnt >= 3'd4) && ratio_ok && (center < 12'd480);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cur_col <= 1'b0;
            cur_len <= '0;
            r0      <= '0;
            r1      <= '0;
            r2      <= '0;
            r3      <= '0;
            cnt     <= '0;
        end else if (scan_clr || (rt.vld && rt.eol)) begin
            // Each line starts behind one virtual white pixel.
            cur_col <= 1'b1;
            cur_len <= 9'd1;
            r0      <= '0;
            r1      <= '0;
            r2      <= '0;
            r3      <= '0;
            cnt     <= '0;
        end else if (rt.vld) begin
            if (ext) begin
                cur_len <= len_inc;
            end else begin
                r0      <= r1;
                r1      <= r2;
                r2      <= r3;
                r3      <= cur_len;
                cnt     <= cnt_inc;
                cur_col <= pixel_reading;
                cur_len <= 9'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            horz_patterns <= '0;
            vert_patterns <= '0;
        end else if (scan_clr) begin
            horz_patterns <= '0;
            vert_patterns <= '0;
        end else if (hit) begin
            if (rt.vert) begin
                vert_patterns[center[8:0]] <= 1'b1;
            end else begin
                horz_patterns[center[8:0]] <= 1'b1;
            end
        end
    end

    assign patterns_valid = (state == S_DONE);
    assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_finder_scan.sv
// Directed bench for finder_scan on a 16x16 frame with an exact-latency memory model.
// Latency: each scan is checked against 2*(W*H+RL)+1 cycles from the start edge.
// Memory never stalls: pixel for the address of cycle t is valid during cycle t+RL.
module tb_finder_scan;

    localparam int W      = 16;
    localparam int H      = 16;
    localparam int RL     = 2;
    localparam int NPIX   = W * H;
    localparam int EXP_PV = 2 * (NPIX + RL) + 1;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         start_scan;
    logic         pixel_reading;
    logic [19:0]  address_reading;
    logic [479:0] horz_patterns;
    logic [479:0] vert_patterns;
    logic         patterns_valid;
    logic         busy;

    logic        frame [0:NPIX-1];
    logic [19:0] mem_a [0:RL-1];

    int n_chk = 0;
    int n_err = 0;

    finder_scan #(.HEIGHT(H), .WIDTH(W), .READ_LATENCY(RL)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_scan      (start_scan),
        .pixel_reading   (pixel_reading),
        .address_reading (address_reading),
        .horz_patterns   (horz_patterns),
        .vert_patterns   (vert_patterns),
        .patterns_valid  (patterns_valid),
        .busy            (busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        mem_a[0] <= address_reading;
        for (int i = 1; i < RL; i++) begin
            mem_a[i] <= mem_a[i-1];
        end
    end

    assign pixel_reading = frame[mem_a[RL-1][7:0]];

    task automatic check(input string tag, input logic [479:0] got, input logic [479:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [479:0] bit_at(input int i);
        logic [479:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < NPIX; i++) frame[i] = 1'b1;
    endtask

    task automatic blk(input int x, input int y);
        frame[x + y * W] = 1'b0;
    endtask

    task automatic load_finder();
        clear_frame();
        for (int yy = 2; yy <= 8; yy++) begin
            for (int xx = 2; xx <= 8; xx++) begin
                if (xx == 2 || xx == 8 || yy == 2 || yy == 8 ||
                    (xx >= 4 && xx <= 6 && yy >= 4 && yy <= 6)) blk(xx, yy);
            end
        end
    endtask

    // row 5: B W BBB W B at x=4..10
    task automatic load_row5();
        clear_frame();
        blk(4, 5); blk(6, 5); blk(7, 5); blk(8, 5); blk(10, 5);
    endtask

    // Start a scan, optionally pulse start_scan again in cycle inj, and
    // verify completion timing plus final bitmaps.
    task automatic scan_and_check(input string pfx, input int inj,
                                  input logic [479:0] exp_h, input logic [479:0] exp_v);
        int pv_at, pv_cnt, busy_cnt;
        pv_at = 0; pv_cnt = 0; busy_cnt = 0;
        @(negedge clk_in) start_scan = 1'b1;
        @(posedge clk_in);
        for (int c = 1; c <= EXP_PV + 6; c++) begin
            @(negedge clk_in);
            start_scan = (c == inj);
            if (busy) busy_cnt++;
            if (patterns_valid) begin
                pv_cnt++;
                if (pv_at == 0) pv_at = c;
            end
        end
        start_scan = 1'b0;
        check({pfx, "_pv_cycle"}, 480'(pv_at), 480'(EXP_PV));
        check({pfx, "_pv_width"}, 480'(pv_cnt), 480'(1));
        check({pfx, "_busy_span"}, 480'(busy_cnt), 480'(EXP_PV));
        check({pfx, "_horz"}, horz_patterns, exp_h);
        check({pfx, "_vert"}, vert_patterns, exp_v);
    endtask

    initial begin
        rst_in     = 1'b0;
        start_scan = 1'b0;
        clear_frame();
        repeat (3) @(negedge clk_in);
        check("rst_addr", 480'(address_reading), 480'(0));
        check("rst_horz", horz_patterns, '0);
        check("rst_vert", vert_patterns, '0);
        check("rst_pv", 480'(patterns_valid), 480'(0));
        check("rst_busy", 480'(busy), 480'(0));
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // All-white frame: nothing found, exact completion timing
        scan_and_check("white", 0, '0, '0);

        // Scale-1 pattern on row 5, center 10-1-1-(3>>1) = 7
        load_row5();
        scan_and_check("row5", 0, bit_at(7), '0);

        // Row 0 scale-2 from x=0: center 13-2-2-3 = 6
        // Row 3 1:1:1:1:1 -> T=5, rejected
        // Row 9 1:1:3:1:1 at x=9..15, closed by line end: center 15-1-1-1 = 12
        clear_frame();
        blk(0, 0); blk(1, 0);
        for (int xx = 4; xx <= 9; xx++) blk(xx, 0);
        blk(12, 0); blk(13, 0);
        blk(0, 3); blk(2, 3); blk(4, 3);
        blk(9, 9); blk(11, 9); blk(12, 9); blk(13, 9); blk(15, 9);
        scan_and_check("scale2", 0, bit_at(6) | bit_at(12), '0);

        // Full 7x7 finder at (2,2): center row and column 5
        load_finder();
        scan_and_check("finder", 0, bit_at(5), bit_at(5));

        // Stray start_scan mid horizontal scan is ignored
        scan_and_check("midstart", 100, bit_at(5), bit_at(5));

        // Reset in the middle of the vertical scan
        @(negedge clk_in) start_scan = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in) start_scan = 1'b0;
        repeat (299) @(negedge clk_in);
        check("pre_rst_horz", horz_patterns, bit_at(5));
        check("pre_rst_busy", 480'(busy), 480'(1));
        rst_in = 1'b0;
        #1;
        check("mid_rst_addr", 480'(address_reading), 480'(0));
        check("mid_rst_horz", horz_patterns, '0);
        check("mid_rst_vert", vert_patterns, '0);
        check("mid_rst_pv", 480'(patterns_valid), 480'(0));
        check("mid_rst_busy", 480'(busy), 480'(0));
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (4) @(negedge clk_in);
        check("post_rst_idle", 480'(busy), 480'(0));

        // New frame after reset yields only its own bits
        load_row5();
        scan_and_check("restart", 0, bit_at(7), '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
